// File: rtl/if_stage.sv
// Instruction-fetch stage: next-PC selection, single-outstanding inst-SRAM fetch,
// one-entry return buffer and valid/allow-in handoff of {pc, inst} to ID.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h1c00_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ds_allow_in,
    input  logic [33:0] br_bus,
    output logic        fs_to_ds_valid,
    output logic [63:0] fs_ds_bus,
    output logic        inst_sram_req,
    output logic [31:0] inst_sram_addr,
    input  logic        inst_sram_addr_ok,
    input  logic        inst_sram_data_ok,
    input  logic [31:0] inst_sram_rdata
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT
    } req_state_t;

    req_state_t  state, state_n;

    logic [31:0] fs_pc;
    logic        fs_valid;
    logic [31:0] req_addr;
    logic [31:0] inst_buf;
    logic        inst_buf_valid;
    logic [31:0] br_buf_target;
    logic        br_buf_valid;

    logic        br_stall, br_taken, redirect;
    logic [31:0] br_target;
    logic        outstanding, data_ret;
    logic        fs_ready_go, handoff, slot_free, can_issue;
    logic        launch, accept, req;
    logic [31:0] nextpc, addr, fs_inst;

    assign br_stall  = br_bus[33];
    assign br_taken  = br_bus[32];
    assign br_target = br_bus[31:0];
    assign redirect  = br_taken & ~br_stall;

    assign outstanding = (state == S_WAIT);
    assign data_ret    = outstanding & inst_sram_data_ok;

    assign fs_ready_go    = inst_buf_valid | data_ret;
    assign fs_to_ds_valid = fs_valid & fs_ready_go;
    assign handoff        = fs_to_ds_valid & ds_allow_in;
    assign slot_free      = ~fs_valid | handoff;

    // Returned word is bypassed straight to ID; zero when nothing is presented.
    assign fs_inst   = inst_buf_valid ? inst_buf
                     : (data_ret ? inst_sram_rdata : '0);
    assign fs_ds_bus = {fs_pc, fs_inst};

    assign nextpc = br_buf_valid ? br_buf_target
                  : (redirect ? br_target : fs_pc + 32'd4);

    // Gating with reset keeps the memory side quiet while reset is held.
    assign can_issue = slot_free & ~br_stall & ~reset;

    always_comb begin
        state_n = state;
        launch  = 1'b0;
        req     = 1'b0;
        addr    = '0;
        case (state)
            S_IDLE: begin
                if (can_issue)
                    launch = 1'b1;
            end
            S_REQ: begin
                req  = 1'b1;
                addr = req_addr;
                if (inst_sram_addr_ok)
                    state_n = S_WAIT;
            end
            S_WAIT: begin
                if (inst_sram_data_ok) begin
                    if (can_issue)
                        launch = 1'b1;
                    else
                        state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
        // A launch drives the request combinationally so addr_ok can land the same cycle.
        if (launch) begin
            req     = 1'b1;
            addr    = nextpc;
            state_n = inst_sram_addr_ok ? S_WAIT : S_REQ;
        end
    end

    assign accept         = req & inst_sram_addr_ok;
    assign inst_sram_req  = req;
    assign inst_sram_addr = addr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            req_addr <= '0;
        end else begin
            state <= state_n;
            if (launch)
                req_addr <= nextpc;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fs_pc    <= RESET_PC - 32'd4;
            fs_valid <= 1'b0;
        end else begin
            if (accept) begin
                fs_pc    <= addr;
                fs_valid <= 1'b1;
            end else if (handoff) begin
                fs_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inst_buf       <= '0;
            inst_buf_valid <= 1'b0;
        end else begin
            if (data_ret & ~handoff) begin
                inst_buf       <= inst_sram_rdata;
                inst_buf_valid <= 1'b1;
            end else if (handoff) begin
                inst_buf_valid <= 1'b0;
            end
        end
    end

    // A redirect not consumed by this cycle's launch is parked; a fresh one beats the clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            br_buf_valid  <= 1'b0;
            br_buf_target <= '0;
        end else begin
            if (redirect & ~(launch & ~br_buf_valid)) begin
                br_buf_valid  <= 1'b1;
                br_buf_target <= br_target;
            end else if (accept) begin
                br_buf_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed pipeline scenarios plus randomized memory/ID
// behaviour scored against a transaction-level fetch model.
module tb_if_stage;

    localparam logic [31:0] RESET_PC = 32'h1c00_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        ds_allow_in = 1'b0;
    logic [33:0] br_bus = '0;
    logic        fs_to_ds_valid;
    logic [63:0] fs_ds_bus;
    logic        inst_sram_req;
    logic [31:0] inst_sram_addr;
    logic        inst_sram_addr_ok = 1'b0;
    logic        inst_sram_data_ok = 1'b0;
    logic [31:0] inst_sram_rdata = '0;

    if_stage #(.RESET_PC(RESET_PC)) dut (
        .clk               (clk),
        .reset             (reset),
        .ds_allow_in       (ds_allow_in),
        .br_bus            (br_bus),
        .fs_to_ds_valid    (fs_to_ds_valid),
        .fs_ds_bus         (fs_ds_bus),
        .inst_sram_req     (inst_sram_req),
        .inst_sram_addr    (inst_sram_addr),
        .inst_sram_addr_ok (inst_sram_addr_ok),
        .inst_sram_data_ok (inst_sram_data_ok),
        .inst_sram_rdata   (inst_sram_rdata)
    );

    always #5 clk = ~clk;

    int unsigned checks = 0;
    int unsigned errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hdead_beef;
    endfunction

    // stimulus for the next cycle
    logic        nx_allow, nx_stall, nx_taken;
    logic [31:0] nx_target;
    int unsigned aok_pct, dly_min, dly_max;

    // memory model (one outstanding read)
    logic        mem_busy;
    int unsigned mem_cnt;
    logic [31:0] mem_addr;

    // fetch model
    logic [31:0] fq[$];
    logic [31:0] last_pc, pend_t;
    logic        pend_v;
    logic        prev_req, prev_aok, prev_hold;
    logic [31:0] prev_addr;
    logic [63:0] prev_bus;
    int unsigned idle_cycles;

    // observations for directed checks
    logic        obs_req, obs_valid;
    logic [31:0] obs_addr;
    logic [63:0] obs_bus;

    task automatic model_clear();
        fq.delete();
        last_pc     = RESET_PC - 32'd4;
        pend_v      = 1'b0;
        pend_t      = '0;
        mem_busy    = 1'b0;
        mem_cnt     = 0;
        mem_addr    = '0;
        prev_req    = 1'b0;
        prev_aok    = 1'b0;
        prev_hold   = 1'b0;
        prev_addr   = '0;
        prev_bus    = '0;
        idle_cycles = 0;
        nx_allow    = 1'b0;
        nx_stall    = 1'b0;
        nx_taken    = 1'b0;
        nx_target   = '0;
    endtask

    task automatic do_reset();
        reset             = 1'b1;
        ds_allow_in       = 1'b0;
        br_bus            = '0;
        inst_sram_addr_ok = 1'b0;
        inst_sram_data_ok = 1'b0;
        inst_sram_rdata   = $urandom;
        #1;
        check_eq("rst_req",   inst_sram_req, 1'b0);
        check_eq("rst_addr",  inst_sram_addr, 32'h0);
        check_eq("rst_valid", fs_to_ds_valid, 1'b0);
        check_eq("rst_bus",   fs_ds_bus, {RESET_PC - 32'd4, 32'h0});
        model_clear();
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic cycle();
        logic        dok, in_req, launch, accept, hand, redir;
        logic [31:0] exp_pc, exp_addr;
        ds_allow_in       = nx_allow;
        br_bus            = {nx_stall, nx_taken, nx_target};
        dok               = mem_busy && (mem_cnt == 0);
        inst_sram_data_ok = dok;
        inst_sram_rdata   = dok ? mem_word(mem_addr) : $urandom;
        inst_sram_addr_ok = ($urandom_range(99, 0) < aok_pct);
        #1;
        obs_req   = inst_sram_req;
        obs_addr  = inst_sram_addr;
        obs_valid = fs_to_ds_valid;
        obs_bus   = fs_ds_bus;

        in_req = prev_req & ~prev_aok;
        launch = inst_sram_req & ~in_req;
        accept = inst_sram_req & inst_sram_addr_ok;
        hand   = fs_to_ds_valid & ds_allow_in;
        redir  = nx_taken & ~nx_stall;

        if (in_req) begin
            check_eq("req_held",  inst_sram_req, 1'b1);
            check_eq("addr_held", inst_sram_addr, prev_addr);
        end
        if (prev_hold) begin
            check_eq("hold_valid", fs_to_ds_valid, 1'b1);
            check_eq("hold_bus",   fs_ds_bus, prev_bus);
        end
        if (hand) begin
            check_eq("out_has_owner", fq.size() != 0, 1'b1);
            if (fq.size() != 0) begin
                exp_pc = fq.pop_front();
                check_eq("out_bus", fs_ds_bus, {exp_pc, mem_word(exp_pc)});
            end
            idle_cycles = 0;
        end else begin
            idle_cycles++;
        end
        if (launch) begin
            exp_addr = pend_v ? pend_t : (redir ? nx_target : last_pc + 32'd4);
            check_eq("launch_addr",  inst_sram_addr, exp_addr);
            check_eq("launch_stall", nx_stall, 1'b0);
            check_eq("launch_slot",  fq.size(), 0);
            check_eq("launch_busy",  mem_busy & ~dok, 1'b0);
        end

        if (accept) begin
            fq.push_back(inst_sram_addr);
            last_pc = inst_sram_addr;
        end
        if (redir & ~(launch & ~pend_v)) begin
            pend_v = 1'b1;
            pend_t = nx_target;
        end else if (accept) begin
            pend_v = 1'b0;
        end

        if (dok)
            mem_busy = 1'b0;
        else if (mem_busy)
            mem_cnt--;
        if (accept) begin
            mem_busy = 1'b1;
            mem_addr = inst_sram_addr;
            mem_cnt  = $urandom_range(dly_max, dly_min);
        end

        prev_req  = inst_sram_req;
        prev_aok  = inst_sram_addr_ok;
        prev_addr = inst_sram_addr;
        prev_hold = fs_to_ds_valid & ~ds_allow_in;
        prev_bus  = fs_ds_bus;
        @(negedge clk);
    endtask

    initial begin
        aok_pct = 100;
        dly_min = 0;
        dly_max = 0;
        model_clear();
        @(negedge clk);

        // back-to-back fetch after reset
        do_reset();
        nx_allow = 1'b1;
        cycle();
        check_eq("t1_req0",  obs_req, 1'b1);
        check_eq("t1_addr0", obs_addr, 32'h1c00_0000);
        cycle();
        check_eq("t1_addr1",  obs_addr, 32'h1c00_0004);
        check_eq("t1_valid1", obs_valid, 1'b1);
        cycle();
        check_eq("t1_addr2",  obs_addr, 32'h1c00_0008);
        check_eq("t1_valid2", obs_valid, 1'b1);

        // ID back-pressure for 3 cycles
        do_reset();
        nx_allow = 1'b0;
        cycle();
        for (int i = 0; i < 3; i++) begin
            cycle();
            check_eq("t2_noreq", obs_req, 1'b0);
            check_eq("t2_valid", obs_valid, 1'b1);
            check_eq("t2_bus",   obs_bus, {32'h1c00_0000, mem_word(32'h1c00_0000)});
        end
        nx_allow = 1'b1;
        cycle();
        check_eq("t2_req",  obs_req, 1'b1);
        check_eq("t2_addr", obs_addr, 32'h1c00_0004);

        // taken branch during handoff of 1c000004
        nx_taken  = 1'b1;
        nx_target = 32'h1c00_0100;
        cycle();
        check_eq("t3_addr", obs_addr, 32'h1c00_0100);
        check_eq("t3_slot", obs_bus, {32'h1c00_0004, mem_word(32'h1c00_0004)});
        nx_taken = 1'b0;
        cycle();
        check_eq("t3_next", obs_addr, 32'h1c00_0104);

        // branch held under stall
        nx_stall  = 1'b1;
        nx_taken  = 1'b1;
        nx_target = 32'h1c00_0200;
        cycle();
        check_eq("t5_noreq0", obs_req, 1'b0);
        cycle();
        check_eq("t5_noreq1", obs_req, 1'b0);
        nx_stall = 1'b0;
        cycle();
        check_eq("t5_req",  obs_req, 1'b1);
        check_eq("t5_addr", obs_addr, 32'h1c00_0200);
        nx_taken = 1'b0;

        // branch pulse while waiting for data: buffered target
        dly_min = 1;
        dly_max = 1;
        cycle();
        check_eq("t4_seq", obs_addr, 32'h1c00_0204);
        nx_taken  = 1'b1;
        nx_target = 32'h1c00_0300;
        cycle();
        check_eq("t4_noreq", obs_req, 1'b0);
        nx_taken = 1'b0;
        cycle();
        check_eq("t4_addr", obs_addr, 32'h1c00_0300);
        cycle();
        cycle();
        check_eq("t4_cleared", obs_addr, 32'h1c00_0304);

        // async reset mid-WAIT
        cycle();
        do_reset();
        nx_allow = 1'b1;
        dly_min  = 0;
        dly_max  = 0;
        cycle();
        check_eq("t6_refetch", obs_addr, 32'h1c00_0000);
        cycle();

        // randomized traffic
        aok_pct = 60;
        dly_min = 0;
        dly_max = 3;
        for (int n = 0; n < 2000; n++) begin
            if (n == 1000)
                do_reset();
            nx_allow  = ($urandom_range(99, 0) < 70);
            nx_stall  = ($urandom_range(99, 0) < 15);
            nx_taken  = ~(prev_req & ~prev_aok) & ~pend_v & ($urandom_range(99, 0) < 10);
            nx_target = 32'h1c00_0000 | ($urandom & 32'h0000_fffc);
            cycle();
            check_eq("progress", idle_cycles <= 200, 1'b1);
            if (idle_cycles > 200)
                break;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
